pipe_regs: RTL
==============

Name: pipe_regs

Overview:
- Parametrised multi-stage pipeline register chain; generalises the plain resettable flop into STAGES elastic stages.
- Each stage carries a valid bit and uses valid/ready backpressure with bubble collapsing.
- Adds synchronous flush and an occupancy count.
- Sits between processor pipeline phases (IF/ID/EX/MEM/WB latches) and anywhere a delayed, stallable datapath is needed.

Parameters:
N, 64, data width in bits.
STAGES, 3, number of register stages (>=1).
RESET_VAL, '0 (N bits), value loaded into every data register on reset.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  upstream presents d this cycle.
in_ready  output  1  chain accepts d this cycle.
d  input  N  input data.
flush  input  1  synchronous clear of all in-flight entries.
out_valid  output  1  last stage holds valid data.
out_ready  input  1  downstream consumes q this cycle.
q  output  N  last-stage data register.
occupancy  output  $clog2(STAGES+1)  registered count of valid stages.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port named reset, sampled only at posedge clk.
- Reset values: all valid bits 0; all data registers RESET_VAL; occupancy 0. Outputs: out_valid=0, q=RESET_VAL, in_ready=1 (when flush=0).
- Stage indexing: 0 is input side, STAGES-1 drives q/out_valid.
- Ready chain (combinational):
  - rdy[STAGES] = out_ready.
  - rdy[i] = !valid[i] || rdy[i+1].
  - in_ready = rdy[0] && !flush.
- Stage i load condition: rdy[i] is 1.
  - valid[i] <= valid[i-1] (in_valid && in_ready for stage 0).
  - data[i] <= data[i-1] (d for stage 0) only when the incoming valid is 1; otherwise data holds.
- Transfers:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - A stage is never overwritten while valid and stalled. Data is never duplicated or dropped.
- Latency: empty chain with out_ready=1 gives d at q exactly STAGES cycles after acceptance. Throughput is 1 per cycle.
- Bubble collapsing: with out_ready=0, new entries advance until they hit the first valid stage. The chain fills to STAGES entries, then in_ready=0.
- Full + out_ready=1: in_ready=1 in the same cycle (combinational pass-through of out_ready). Simultaneous in/out transfer keeps occupancy constant.
- Flush:
  - At the next edge all valid bits become 0 and occupancy becomes 0.
  - in_ready=0 during a flush cycle, so nothing is accepted.
  - out_valid still reflects pre-flush state during the flush cycle. A downstream transfer in that cycle is legal and counted.
- Occupancy: registered counter.
  - +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
  - Must always equal popcount(valid).
  - Never exceeds STAGES and never underflows.
- Priority: reset > flush > normal operation. Reset mid-stream discards all entries.
- STAGES=1 must work: a single elastic register with full/empty behaviour.

Optional Feature:
- Macro: PIPE_REGS_CLEAR_ON_FLUSH_EN.
- Defined: flush also loads RESET_VAL into every data register at the same edge, so q reads RESET_VAL after a flush.
- Undefined: flush clears valid bits only; data registers retain stale contents.

Decomposition:
- Package pipe_pkg:
  - Function occ_width(stages) = $clog2(stages+1).
  - Typedef for the per-stage control struct {valid, rdy}.
- Sub-module pipe_stage (params N, RESET_VAL):
  - Ports clk, reset, flush, in valid/data, load, out valid/data.
  - Instantiated STAGES times in a generate loop.
  - Top level holds the ready chain and the occupancy counter.

Test Plan:
1. Reset, then stream d=0x1,0x2,0x3,0x4 with out_ready=1 (STAGES=3) -> q=0x1 with out_valid=1 at the 3rd edge after the first accept, then one value per cycle; occupancy steady at 3.
2. out_ready=0, push 5 values with in_valid=1 -> first 3 accepted, in_ready=0 afterwards, occupancy=3; raise out_ready -> q emits 1,2,3 in order, then values 4,5 follow.
3. Full chain, in_valid=1 and out_ready=1 in the same cycle -> in_ready=1, one in and one out, occupancy stays 3.
4. Occupancy 2, assert flush for one cycle with in_valid=1 -> next cycle out_valid=0, occupancy=0, input not accepted. With PIPE_REGS_CLEAR_ON_FLUSH_EN, q=RESET_VAL; without it, q holds its old value.
5. Mid-stream assert reset with flush=1 and in_valid=1 -> all valids 0, q=RESET_VAL, occupancy 0 at the next edge; normal streaming resumes the cycle after reset drops.
6. Random valid/ready toggling for 10k cycles, STAGES in {1,3,5}, N in {8,64} -> scoreboard shows in-order, lossless, duplicate-free output and occupancy==popcount(valid) every cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and helpers for the elastic pipeline register chain.
//   occ_width(stages) : width of an occupancy counter that can hold 0..stages.
//   stage_ctrl_t      : per-stage handshake view {valid, rdy} used by the
//                       top level to build the backward ready chain.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Number of bits needed to represent every count from 0 up to 'stages'.
  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  // valid : the stage currently holds a live entry.
  // rdy   : the stage will load at the next edge (it is empty, or everything
  //         downstream of it is moving).
  typedef struct packed {
    logic valid;
    logic rdy;
  } stage_ctrl_t;

endpackage : pipe_pkg

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One elastic register slot of the pipeline chain: a valid bit plus an N-bit
// data register. The slot loads whatever its upstream neighbour presents
// when load_i is high; data is only overwritten by a valid incoming entry so
// an empty slot keeps its last contents.
//
// Optional build macro:
//   PIPE_REGS_CLEAR_ON_FLUSH_EN : when defined, flush also returns the data
//                                 register to RESET_VAL; otherwise flush only
//                                 clears the valid bit and data stays stale.
//
// Ports:
//   clk          in   clock, all updates on the rising edge
//   reset        in   synchronous active-high reset (highest priority)
//   flush        in   synchronous clear of the valid bit
//   load_i       in   slot may take its upstream value this cycle
//   in_valid_i   in   upstream entry is valid
//   in_data_i    in   upstream data
//   out_valid_o  out  slot holds a valid entry
//   out_data_o   out  slot data register
// -----------------------------------------------------------------------------
module pipe_stage #(
  parameter int             N         = 64,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load_i,
  input  logic         in_valid_i,
  input  logic [N-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [N-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [N-1:0] data_q,  data_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = in_valid_i;
      // A bubble moving in must not clobber the data register.
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // stage samples its neighbour's pre-edge value and the chain shifts by
  // exactly one slot per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      // NOTE: the data register is reset too because q must read RESET_VAL
      // out of reset; this is a handful of flops, not a memory array.
      data_q  <= RESET_VAL;
    end else if (flush) begin
      valid_q <= 1'b0;
`ifdef PIPE_REGS_CLEAR_ON_FLUSH_EN
      data_q  <= RESET_VAL;
`else
      data_q  <= data_q;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule : pipe_stage

// File: rtl/pipe_regs.sv
// -----------------------------------------------------------------------------
// pipe_regs
// Parametrised chain of STAGES elastic pipeline registers with valid/ready
// backpressure, bubble collapsing, synchronous flush and a registered
// occupancy count. Stage 0 is the input side; stage STAGES-1 drives q and
// out_valid. An empty chain with out_ready high delivers d at q STAGES
// cycles after acceptance at a throughput of one entry per cycle.
//
// Optional build macro:
//   PIPE_REGS_CLEAR_ON_FLUSH_EN : flush also reloads every data register
//                                 with RESET_VAL (see pipe_stage).
//
// Parameters:
//   N          data width
//   STAGES     number of register stages (>= 1)
//   RESET_VAL  data register value after reset
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset, beats flush
//   in_valid   in   upstream presents d
//   in_ready   out  chain accepts d this cycle (0 during flush)
//   d          in   input data
//   flush      in   drop every in-flight entry at the next edge
//   out_valid  out  last stage holds valid data
//   out_ready  in   downstream consumes q this cycle
//   q          out  last-stage data register
//   occupancy  out  registered number of valid stages
// -----------------------------------------------------------------------------
module pipe_regs
  import pipe_pkg::*;
#(
  parameter int           N         = 64,
  parameter int           STAGES    = 3,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 d,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 q,
  output logic [occ_width(STAGES)-1:0] occupancy
);

  localparam int               OCC_W   = occ_width(STAGES);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  logic [STAGES-1:0] stage_valid;
  logic [N-1:0]      stage_data [STAGES];
  stage_ctrl_t [STAGES-1:0] ctrl;

  logic in_xfer;
  logic out_xfer;

  logic [OCC_W-1:0] occ_q, occ_d;

  // Backward ready chain: a stage can load when it is empty or when the
  // stage after it is loading. The running value is carried in a local
  // accumulator walking from the output end, so the chain is a plain
  // priority cascade with out_ready as its seed.
  always_comb begin
    logic rdy_acc;
    rdy_acc = out_ready;
    ctrl    = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ctrl[i].valid = stage_valid[i];
      rdy_acc       = !ctrl[i].valid || rdy_acc;
      ctrl[i].rdy   = rdy_acc;
    end
  end

  // A full chain still accepts when out_ready is high: out_ready passes
  // combinationally all the way back to in_ready.
  assign in_ready  = ctrl[0].rdy && !flush;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = ctrl[STAGES-1].valid;
  assign out_xfer  = out_valid && out_ready;
  assign q         = stage_data[STAGES-1];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic         up_valid;
    logic [N-1:0] up_data;

    if (g == 0) begin : g_head
      // Only an accepted beat enters stage 0; otherwise a bubble does.
      assign up_valid = in_xfer;
      assign up_data  = d;
    end else begin : g_body
      assign up_valid = stage_valid[g-1];
      assign up_data  = stage_data[g-1];
    end

    pipe_stage #(
      .N         (N),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .load_i      (ctrl[g].rdy),
      .in_valid_i  (up_valid),
      .in_data_i   (up_data),
      .out_valid_o (stage_valid[g]),
      .out_data_o  (stage_data[g])
    );
  end

  // Occupancy tracks transfers rather than recounting valid bits, which
  // keeps it a registered output with no popcount tree.
  always_comb begin
    occ_d = occ_q;
    if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OCC_ONE;
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  // A downstream transfer during flush is legal, but every entry is gone
  // after the edge anyway, so flush simply zeroes the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule : pipe_regs
